// File: rtl/reg_bank_scan_8x16.sv
// Eight-entry register bank feeding a 16-bit 8:1 mux, with a scan sequencer
// that steps the mux selects through a programmable, wrapping index range.
module reg_bank_scan_8x16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [2:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             start,
    input  logic [2:0]       first,
    input  logic [2:0]       last,
    input  logic             hold,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [WIDTH-1:0] o4,
    output logic [WIDTH-1:0] o5,
    output logic [WIDTH-1:0] o6,
    output logic [WIDTH-1:0] o7,
    output logic             s2,
    output logic             s1,
    output logic             s0,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StScan = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];

    logic [1:0] state_q, state_d;
    logic [2:0] sel_q,   sel_d;
    // Only the end index needs retaining: the start index is loaded straight
    // into sel when the scan launches and never consulted again.
    logic [2:0] last_q,  last_d;
    logic       valid_q, valid_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    // Register write port; allowed in every state, no write-through.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
            if (we && (waddr == 3'(i))) begin
                regs_d[i] = wdata;
            end
        end
    end

    // Scan sequencer next-state: valid/busy/done are decided here and
    // registered so no output is combinational from an input.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    last_d  = last;
                    sel_d   = first;
                    state_d = StScan;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            StScan: begin
                busy_d = 1'b1;
                if (hold) begin
                    // Current index already presented; stall without re-presenting it.
                    valid_d = 1'b0;
                end else if (sel_q == last_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    sel_d   = sel_q + 3'd1;
                    valid_d = 1'b1;
                end
            end

            StDone: begin
                // start is deliberately ignored here, which guarantees one
                // idle cycle between back-to-back scans.
                state_d = StIdle;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and register bank; synchronous reset overrides writes and start.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            state_q <= StIdle;
            sel_q   <= 3'd0;
            last_q  <= 3'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o0 = regs_q[0];
    assign o1 = regs_q[1];
    assign o2 = regs_q[2];
    assign o3 = regs_q[3];
    assign o4 = regs_q[4];
    assign o5 = regs_q[5];
    assign o6 = regs_q[6];
    assign o7 = regs_q[7];

    assign {s2, s1, s0} = sel_q;
    assign valid        = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_reg_bank_scan_8x16.sv
// Self-checking bench for reg_bank_scan_8x16: directed scenarios followed by
// random traffic, all compared against a queue-based scan model.
module tb_reg_bank_scan_8x16;

    logic        clk;
    logic        reset, we, start, hold;
    logic [2:0]  waddr, first, last;
    logic [15:0] wdata;
    logic [15:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic        s2, s1, s0, valid, busy, done;

    logic [15:0] ov [8];
    assign ov[0] = o0;
    assign ov[1] = o1;
    assign ov[2] = o2;
    assign ov[3] = o3;
    assign ov[4] = o4;
    assign ov[5] = o5;
    assign ov[6] = o6;
    assign ov[7] = o7;

    reg_bank_scan_8x16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .start (start),
        .first (first),
        .last  (last),
        .hold  (hold),
        .o0    (o0),
        .o1    (o1),
        .o2    (o2),
        .o3    (o3),
        .o4    (o4),
        .o5    (o5),
        .o6    (o6),
        .o7    (o7),
        .s2    (s2),
        .s1    (s1),
        .s0    (s0),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid_seen;
    int n_done_seen;
    logic [15:0] mux_seen [$];

    // Reference model: register array plus the list of indices still to visit.
    logic [15:0] m_reg [8];
    int          visits [$];
    bit          m_scan, m_valid, m_busy, m_done;
    logic [2:0]  m_sel;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int n;
        if (reset) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 16'd0;
            visits.delete();
            m_scan = 0; m_valid = 0; m_busy = 0; m_done = 0; m_sel = 3'd0;
        end else begin
            if (we) m_reg[waddr] = wdata;
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (m_scan) begin
                if (hold) begin
                    m_valid = 0;
                end else begin
                    void'(visits.pop_front());
                    if (visits.size() == 0) begin
                        m_scan  = 0;
                        m_done  = 1;
                        m_valid = 0;
                    end else begin
                        m_sel   = 3'(visits[0]);
                        m_valid = 1;
                    end
                end
            end else if (start) begin
                n = int'(3'(last - first)) + 1;
                for (int k = 0; k < n; k++) visits.push_back(int'(3'(first + 3'(k))));
                m_sel   = first;
                m_scan  = 1;
                m_valid = 1;
                m_busy  = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [127:0] mcat;
        for (int i = 0; i < 8; i++) mcat[i*16 +: 16] = m_reg[i];
        check_eq("regs",  {o7, o6, o5, o4, o3, o2, o1, o0}, mcat);
        check_eq("sel",   {s2, s1, s0}, m_sel);
        check_eq("valid", valid, m_valid);
        check_eq("busy",  busy, m_busy);
        check_eq("done",  done, m_done);
        if (m_valid) check_eq("mux", ov[{s2, s1, s0}], m_reg[m_sel]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
        if (valid === 1'b1) begin
            n_valid_seen++;
            mux_seen.push_back(ov[{s2, s1, s0}]);
        end
        if (done === 1'b1) n_done_seen++;
    endtask

    task automatic quiet_inputs();
        reset = 0; we = 0; start = 0; hold = 0;
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while (m_busy && cyc < 40) begin
            tick();
            cyc++;
        end
        check_eq(tag, busy, 1'b0);
    endtask

    // Launch a scan and steer hold/write/reset from the model's current index.
    task automatic run_scan(input logic [2:0] f, input logic [2:0] l, input bit keep_start,
                            input int hold_sel, input int hold_n, input int wr_sel,
                            input logic [2:0] wr_addr, input logic [15:0] wr_data,
                            input int rst_sel, input int exp_valid, input int exp_done);
        int  hold_left;
        int  cyc;
        bit  wrote;
        bit  rst_hit;
        hold_left = hold_n; cyc = 0; wrote = 0; rst_hit = 0;
        n_valid_seen = 0; n_done_seen = 0;
        mux_seen.delete();
        first = f; last = l; start = 1;
        tick();
        start = keep_start;
        while (m_busy && cyc < 40) begin
            hold = m_scan && (int'(m_sel) == hold_sel) && (hold_left > 0);
            if (hold) hold_left--;
            we = m_scan && (int'(m_sel) == wr_sel) && !wrote;
            if (we) begin
                waddr = wr_addr; wdata = wr_data; wrote = 1;
            end
            reset = m_scan && (int'(m_sel) == rst_sel) && !rst_hit;
            if (reset) rst_hit = 1;
            tick();
            cyc++;
        end
        hold = 0; we = 0; reset = 0;
        check_eq("scan_ends_idle", busy, 1'b0);
        check_eq("valid_count", n_valid_seen, exp_valid);
        check_eq("done_count",  n_done_seen,  exp_done);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int wvals [8];
        wvals = '{10, 22, 2, 12, 233, 32, 23, 231};
        m_sel = 3'd0;
        quiet_inputs();
        first = 3'd0; last = 3'd0; waddr = 3'd0; wdata = 16'd0;

        reset = 1;
        tick();
        tick();
        reset = 0;

        for (int i = 0; i < 8; i++) begin
            we = 1; waddr = 3'(i); wdata = 16'(wvals[i]);
            tick();
        end
        we = 0;
        tick();
        for (int i = 0; i < 8; i++) check_eq("init_reg", ov[i], 16'(wvals[i]));

        // Full 0..7 scan: mux sequence must follow the written values in order.
        run_scan(3'd0, 3'd7, 0, -1, 0, -1, 3'd0, 16'd0, -1, 8, 1);
        check_eq("seq_len", mux_seen.size(), 8);
        for (int k = 0; k < 8 && k < mux_seen.size(); k++) check_eq("seq_val", mux_seen[k], 16'(wvals[k]));
        tick();

        // Wrap-around with start held: relaunch only once IDLE is reached.
        run_scan(3'd6, 3'd1, 1, -1, 0, -1, 3'd0, 16'd0, -1, 4, 1);
        tick();
        check_eq("relaunch_busy", busy, 1'b1);
        check_eq("relaunch_sel", {s2, s1, s0}, 3'd6);
        start = 0;
        drain("relaunch_drain");
        tick();

        // Hold for three cycles while sel=3.
        run_scan(3'd2, 3'd4, 0, 3, 3, -1, 3'd0, 16'd0, -1, 3, 1);
        tick();

        // Mid-scan write to reg 5 while sel=4.
        run_scan(3'd4, 3'd6, 0, -1, 0, 4, 3'd5, 16'hBEEF, -1, 3, 1);
        check_eq("o5_beef", o5, 16'hBEEF);
        tick();

        // Single-entry scan.
        run_scan(3'd3, 3'd3, 0, -1, 0, -1, 3'd0, 16'd0, -1, 1, 1);
        tick();

        // Reset while sel=5: abort, no done pulse, bank cleared.
        run_scan(3'd0, 3'd7, 0, -1, 0, -1, 3'd0, 16'd0, 5, 6, 0);
        check_eq("rst_bank", {o7, o6, o5, o4, o3, o2, o1, o0}, 128'd0);
        run_scan(3'd1, 3'd2, 0, -1, 0, -1, 3'd0, 16'd0, -1, 2, 1);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            we    = ($urandom_range(0, 2) == 0);
            waddr = 3'($urandom);
            wdata = 16'($urandom);
            start = ($urandom_range(0, 3) == 0);
            first = 3'($urandom);
            last  = 3'($urandom);
            hold  = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank_scan_8x16.md
Name: reg_bank_scan_8x16

Overview:
- Upstream companion of the 16-bit 8:1 mux.
- Holds eight 16-bit registers and presents them continuously on o0..o7, which drive the mux data inputs i0..i7.
- Contains a scan sequencer that drives the mux selects s2,s1,s0 through a programmable register range, one register per cycle, with a start/busy/done handshake.
- Downstream logic samples the mux output on every cycle where valid is high.

Parameters:
WIDTH, 16, data width of each register and of o0..o7

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
we  input  1  register write enable
waddr  input  3  register index to write
wdata  input  WIDTH  write data
start  input  1  scan request; sampled only in IDLE
first  input  3  first register index of the scan; latched on start
last  input  3  last register index of the scan; latched on start
hold  input  1  pauses the scan while high
o0..o7  output  WIDTH each  register contents, to mux i0..i7
s2,s1,s0  output  1 each  current select, {s2,s1,s0} = sel[2:0], to mux
valid  output  1  mux output corresponds to sel this cycle
busy  output  1  high in SCAN and DONE
done  output  1  one-cycle pulse at the end of a scan

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On any rising edge with reset=1:
  - all eight registers = 0
  - sel = 000, state = IDLE
  - valid = busy = done = 0
  - latched first/last = 000
  - reset has priority over we and start.
- Register write:
  - On a rising edge with we=1, reg[waddr] <= wdata.
  - The new value appears on the corresponding o output after that edge; there is no write-through.
  - Writes are allowed in every state, including mid-scan.
  - A write to the currently selected register changes the mux data from the next cycle; valid is unaffected.
- All outputs are registered. None is combinational from inputs.
- FSM states are IDLE, SCAN, DONE.
- IDLE:
  - valid = 0, busy = 0, done = 0; sel holds its last value.
  - If start=1 at an edge: latch first/last, sel <= first, next state SCAN.
- SCAN:
  - busy = 1; valid = !hold for the current cycle, registered as the state/hold decision described below.
  - Each edge with hold=0:
    - if sel == latched last: next state DONE and sel holds;
    - else sel <= (sel+1) mod 8.
  - Each edge with hold=1: sel and state hold.
  - valid is high in every SCAN cycle in which the current sel has not yet been consumed.
  - Implementation: valid <= 1 on entering SCAN and after every advance. valid <= 0 on an edge where hold=1 is sampled. valid returns to 1 on the edge after hold drops.
- DONE:
  - busy = 1, valid = 0, done = 1 for exactly one cycle.
  - sel holds last.
  - Next state IDLE unconditionally.
- Scan length:
  - Number of valid cycles = ((last - first) mod 8) + 1, in the range 1..8.
  - Wrap-around: first=6, last=1 visits 6,7,0,1.
  - first == last gives a single valid cycle.
- start while busy is ignored; it is not queued.
- Back-to-back scans: DONE is followed by at least one IDLE cycle before the next SCAN. Minimum gap is one cycle with busy=0.
- we and start on the same edge: both take effect. The write completes before the scan's first valid cycle.
- Reset mid-scan: the scan is aborted with no done pulse, and all state clears per the reset rule.
- first/last changing during a scan has no effect; the latched copies are used.

Test Plan:
- Reset, then write 10,22,2,12,233,32,23,231 to regs 0..7 -> after 8 edges o0..o7 read those values, sel=000, busy=valid=done=0.
- start with first=0, last=7, hold=0 -> valid high for 8 consecutive cycles with sel=0..7 in order, mux out sequence 10,22,2,12,233,32,23,231, then a one-cycle done pulse, then busy=0.
- start with first=6, last=1 -> sel sequence 6,7,0,1 with 4 valid cycles, done on the 5th cycle; start=1 held during the scan launches no second scan until the cycle after IDLE is re-entered.
- Scan with first=2, last=4, hold=1 for 3 cycles while sel=3 -> sel stays 3, valid low during the hold, exactly 3 valid cycles total (sel 2,3,4), done after sel=4.
- Mid-scan write of 0xBEEF to reg 5 while sel=4 in scan 4..6 -> o5=0xBEEF when sel=5, valid high; a first=last=3 scan gives exactly 1 valid cycle then done.
- reset asserted while sel=5 in scan 0..7 -> next edge: all registers 0, busy=valid=0, no done pulse; a following start works normally.
